dense_layer_core: RTL and testbench
===================================

Name: dense_layer_core

Overview:
- Compute stage directly downstream of the dense-layer AXI-Lite register block.
- Consumes the `start` and `debug_rst_local` controls from that block and returns `output_y0`, `debug_counter`, `start_time` and `end_time` for host readback.
- Computes one neuron: y0 = bias + sum over i of w[i]*x[i].
- Uses a single sequential MAC, one element per cycle, and timestamps each run with a free-running 64-bit cycle counter.

Parameters:
N_INPUTS, 8, number of input/weight elements (>=1)
DATA_W, 16, signed width of each x and w element
RELU, 0, 1 = clamp negative results to 0 before writing output_y0

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  level run request from register block; a rising edge launches one inference
debug_rst_local  input  1  level; while 1, debug_counter is held at 0
x_flat  input  N_INPUTS*DATA_W  signed inputs, element i at [i*DATA_W +: DATA_W]
w_flat  input  N_INPUTS*DATA_W  signed weights, same packing
bias  input  32  signed bias
output_y0  output  32  signed result of the last completed run
debug_counter  output  32  count of completed runs
start_time  output  64  cycle counter value captured at run launch
end_time  output  64  cycle counter value captured at run completion
busy  output  1  1 while state != IDLE
done  output  1  one-cycle pulse when output_y0 updates

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, all outputs 0, accumulator/index/cycle counter 0, start_q 0.
- Reset mid-run aborts the run with no output update.
- cycle_cnt: 64-bit, +1 every cycle when not in reset; wraps at 2^64.
- start_q registers start every cycle, in any state. start_rise = start & ~start_q.
- Run requests:
  - Only start_rise in IDLE launches a run.
  - Rises during MAC/DONE are ignored and not queued.
  - Holding start high launches exactly one run; software writes 0 then 1 to rerun.
- FSM IDLE -> MAC -> DONE -> IDLE:
  - IDLE: on start_rise: acc <= sign-extended bias, idx <= 0, start_time <= cycle_cnt, go to MAC.
  - MAC: acc <= acc + w[idx]*x[idx]; idx++. When idx == N_INPUTS-1, go to DONE.
  - DONE:
    - output_y0 <= (RELU && acc<0) ? 0 : acc.
    - end_time <= cycle_cnt.
    - done <= 1 for this single cycle.
    - debug_counter++.
    - Return to IDLE.
- Timing:
  - Launch edge E0; the MAC occupies the next N_INPUTS edges; outputs update at edge E0+N_INPUTS+1.
  - end_time - start_time = N_INPUTS+1.
  - A new run may launch on the edge after done (start must have returned low in between).
- Arithmetic:
  - Product is signed 2*DATA_W bits, sign-extended or truncated to 32.
  - Accumulator is 32-bit signed; additions wrap modulo 2^32, with no saturation or overflow flag.
- x_flat, w_flat and bias are sampled live each MAC cycle. The host must keep them stable while busy=1.
- debug_rst_local=1:
  - debug_counter <= 0 every cycle; this takes priority over a DONE increment in the same cycle.
  - No effect on the FSM, cycle_cnt, timestamps or output_y0.
- output_y0, start_time and end_time hold their values between runs.
- start_time updates at launch, before end_time; readers see a new start_time paired with the old end_time while busy.
- debug_counter wraps at 2^32.

Test Plan:
- Basic run, N=4, x={1,2,3,4}, w={5,6,7,8}, bias=10, start 0->1 -> done pulses once 5 edges after launch; output_y0=80; debug_counter=1; end_time-start_time=5; busy high for 5 cycles.
- Signed/ReLU, x={1,2,3,4}, w={-5,-6,-7,-8}, bias=10 -> RELU=0: output_y0=-60 (0xFFFFFFC4); RELU=1: output_y0=0.
- Wrap, x={0x7FFF,0x7FFF,0,0}, w={0x7FFF,0x7FFF,0,0}, bias=0x7FFFFFFF -> output_y0 = 0x7FFFFFFF + 2*0x3FFF0001 mod 2^32 = 0xFFFE0001.
- Level start held high for 50 cycles, plus an extra 0->1 toggle during busy -> exactly one run; debug_counter=1. After start=0 then 1, a second run gives debug_counter=2.
- debug_rst_local held high while a run completes -> debug_counter stays 0; output_y0 still updates. After release, the next run gives debug_counter=1.
- rst asserted 2 cycles into a run -> next cycle busy=0 and all outputs 0; no done pulse. A fresh start_rise afterwards completes normally with output_y0=80.

Source files
------------

// File: rtl/dense_layer_core.sv
// dense_layer_core: single-neuron dense layer, y0 = bias + sum(w[i]*x[i]).
// One sequential MAC step per cycle, with every run timestamped by a free-running
// 64-bit cycle counter for host readback.
module dense_layer_core #(
    parameter int N_INPUTS = 8,
    parameter int DATA_W   = 16,
    parameter int RELU     = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         debug_rst_local,
    input  logic [N_INPUTS*DATA_W-1:0]   x_flat,
    input  logic [N_INPUTS*DATA_W-1:0]   w_flat,
    input  logic [31:0]                  bias,
    output logic [31:0]                  output_y0,
    output logic [31:0]                  debug_counter,
    output logic [63:0]                  start_time,
    output logic [63:0]                  end_time,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic                      start_q;
    logic                      start_rise;
    logic                      launch;
    logic                      mac_en;
    logic                      finish;
    logic [IDX_W-1:0]          idx;
    logic signed [31:0]        acc;
    logic signed [31:0]        result;
    logic [63:0]               cycle_cnt;
    logic signed [DATA_W-1:0]  x_sel;
    logic signed [DATA_W-1:0]  w_sel;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [31:0]        prod_ext;

    // Only a 0->1 transition of the level request counts; a held start is one run.
    assign start_rise = start & ~start_q;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples
        // pre-edge values regardless of block ordering.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> MAC -> DONE -> IDLE; rises outside IDLE are dropped.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (start_rise) state_nxt = MAC;
            MAC:     if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/control decode from the current state.
    always_comb begin
        busy   = (state != IDLE);
        launch = (state == IDLE) && start_rise;
        mac_en = (state == MAC);
        finish = (state == DONE);
    end

    // Select the current element pair; operands are read live from the flat buses.
    always_comb begin
        x_sel = '0;
        w_sel = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (idx == IDX_W'(i)) begin
                x_sel = x_flat[i*DATA_W +: DATA_W];
                w_sel = w_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    assign prod = x_sel * w_sel;

    // Fit the full-precision product to the 32-bit accumulator (sign-extend or truncate).
    generate
        if (2 * DATA_W >= 32) begin : g_prod_trunc
            assign prod_ext = prod[31:0];
        end else begin : g_prod_sext
            assign prod_ext = {{(32 - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end
    endgenerate

    // Optional ReLU clamp applied only when publishing the result.
    assign result = ((RELU != 0) && acc[31]) ? 32'sd0 : acc;

    // Datapath: cycle counter, MAC accumulation, timestamps and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt  <= '0;
            start_q    <= 1'b0;
            acc        <= '0;
            idx        <= '0;
            output_y0  <= '0;
            start_time <= '0;
            end_time   <= '0;
            done       <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            start_q   <= start;
            done      <= 1'b0;
            if (launch) begin
                acc        <= bias;
                idx        <= '0;
                start_time <= cycle_cnt;
            end
            if (mac_en) begin
                acc <= acc + prod_ext;
                idx <= idx + 1'b1;
            end
            if (finish) begin
                output_y0 <= result;
                end_time  <= cycle_cnt;
                done      <= 1'b1;
            end
        end
    end

    // Completed-run counter; the local debug clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || debug_rst_local) begin
            debug_counter <= '0;
        end else if (finish) begin
            debug_counter <= debug_counter + 32'd1;
        end
    end

endmodule

// File: tb/tb_dense_layer_core.sv
// Scoreboard bench for dense_layer_core (N_INPUTS=4): stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_dense_layer_core;

    localparam int N  = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            debug_rst_local;
    logic [N*DW-1:0] x_flat;
    logic [N*DW-1:0] w_flat;
    logic [31:0]     bias;

    logic [31:0] output_y0, debug_counter;
    logic [63:0] start_time, end_time;
    logic        busy, done;

    logic [31:0] y0_r, cnt_r;
    logic [63:0] st_r, et_r;
    logic        busy_r, done_r;

    int vectors     = 0;
    int miscompares = 0;
    int done_seen   = 0;

    typedef struct {
        logic [31:0] y0;
        logic [31:0] y0_relu;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    dense_layer_core #(.N_INPUTS(N), .DATA_W(DW), .RELU(0)) dut (
        .clk(clk), .rst(rst), .start(start), .debug_rst_local(debug_rst_local),
        .x_flat(x_flat), .w_flat(w_flat), .bias(bias),
        .output_y0(output_y0), .debug_counter(debug_counter),
        .start_time(start_time), .end_time(end_time), .busy(busy), .done(done)
    );

    dense_layer_core #(.N_INPUTS(N), .DATA_W(DW), .RELU(1)) dut_relu (
        .clk(clk), .rst(rst), .start(start), .debug_rst_local(debug_rst_local),
        .x_flat(x_flat), .w_flat(w_flat), .bias(bias),
        .output_y0(y0_r), .debug_counter(cnt_r),
        .start_time(st_r), .end_time(et_r), .busy(busy_r), .done(done_r)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [N*DW-1:0] pack4(input logic [15:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("output_y0", output_y0, e.y0);
                check("output_y0_relu", y0_r, e.y0_relu);
                check("relu_done", done_r, 1'b1);
                check("debug_counter", debug_counter, e.cnt);
                check("run_span", end_time - start_time, 64'(N + 1));
            end
        end
    end

    // Launch one run from a start rise; checks latency, busy length and pulse width.
    task automatic run_vec(input logic [N*DW-1:0] xv, input logic [N*DW-1:0] wv,
                           input logic [31:0] b, input logic [31:0] ey,
                           input logic [31:0] ery, input logic [31:0] ecnt);
        int busy_n = 0;
        bit got    = 0;
        x_flat = xv;
        w_flat = wv;
        bias   = b;
        sb.push_back('{ey, ery, ecnt});
        start = 1'b1;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                check("done_latency", 64'(c), 64'(N + 2));
            end else if (busy) begin
                busy_n++;
            end
        end
        if (!got) check("done_timeout", 64'd0, 64'd1);
        check("busy_cycles", 64'(busy_n), 64'(N + 1));
        start = 1'b0;
        @(negedge clk);
        check("done_width", done, 1'b0);
    endtask

    initial begin
        logic [N*DW-1:0] x_basic, w_basic, w_neg, x_wrap;
        int d0;
        x_basic = pack4(16'd1, 16'd2, 16'd3, 16'd4);
        w_basic = pack4(16'd5, 16'd6, 16'd7, 16'd8);
        w_neg   = pack4(-16'sd5, -16'sd6, -16'sd7, -16'sd8);
        x_wrap  = pack4(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000);

        rst = 1'b1; start = 1'b0; debug_rst_local = 1'b0;
        x_flat = '0; w_flat = '0; bias = '0;
        repeat (2) @(negedge clk);
        check("reset_y0", output_y0, 32'd0);
        check("reset_cnt", debug_counter, 32'd0);
        check("reset_start_time", start_time, 64'd0);
        check("reset_end_time", end_time, 64'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic, signed/ReLU and wrapping accumulation.
        run_vec(x_basic, w_basic, 32'd10, 32'd80, 32'd80, 32'd1);
        run_vec(x_basic, w_neg, 32'd10, 32'hFFFF_FFC4, 32'd0, 32'd2);
        run_vec(x_wrap, x_wrap, 32'h7FFF_FFFF, 32'hFFFE_0001, 32'd0, 32'd3);

        // Debug clear pulse zeroes the counter but leaves the result alone.
        debug_rst_local = 1'b1;
        @(negedge clk);
        debug_rst_local = 1'b0;
        check("debug_clear_cnt", debug_counter, 32'd0);
        check("debug_clear_keeps_y0", output_y0, 32'hFFFE_0001);

        // Level start held high with an extra toggle while busy: one run only.
        d0 = done_seen;
        x_flat = x_basic; w_flat = w_basic; bias = 32'd10;
        sb.push_back('{32'd80, 32'd80, 32'd1});
        start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c == 2) start = 1'b0;
            if (c == 3) start = 1'b1;
        end
        check("level_single_run", 64'(done_seen - d0), 64'd1);
        start = 1'b0;
        @(negedge clk);
        run_vec(x_basic, w_basic, 32'd10, 32'd80, 32'd80, 32'd2);

        // Debug clear held across a completion; release then count from 1.
        debug_rst_local = 1'b1;
        run_vec(x_basic, w_neg, 32'd10, 32'hFFFF_FFC4, 32'd0, 32'd0);
        debug_rst_local = 1'b0;
        run_vec(x_basic, w_basic, 32'd10, 32'd80, 32'd80, 32'd1);

        // Reset two cycles into a run aborts it without a done pulse.
        d0 = done_seen;
        start = 1'b1;
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_y0", output_y0, 32'd0);
        check("abort_cnt", debug_counter, 32'd0);
        check("abort_start_time", start_time, 64'd0);
        check("abort_end_time", end_time, 64'd0);
        check("abort_done", done, 1'b0);
        repeat (10) @(negedge clk);
        check("abort_no_done", 64'(done_seen - d0), 64'd0);
        run_vec(x_basic, w_basic, 32'd10, 32'd80, 32'd80, 32'd1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
